// File: rtl/reg_bus_arbiter.sv
// Two-master arbiter for the register-file access port: I2C slave (A, priority/lock) vs internal engine (B).
// Optional B low-address write protection under ARB_WRITE_PROTECT_EN.
module reg_bus_arbiter #(
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned MAX_WAIT = 15,
  parameter logic [7:0]  B_WR_MIN = 8'h40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       a_we,
  input  logic [7:0] a_addr,
  input  logic [7:0] a_wdata,
  input  logic       a_lock,
  output logic       a_ack,
  output logic [7:0] a_rdata,
  input  logic       b_req,
  input  logic       b_we,
  input  logic [7:0] b_addr,
  input  logic [7:0] b_wdata,
  output logic       b_ack,
  output logic [7:0] b_rdata,
  output logic       b_err,
  output logic       ram_write,
  output logic       ram_read,
  output logic [7:0] ram_index,
  output logic [7:0] ram_wdata,
  input  logic [7:0] ram_rdata,
  output logic       owner
);

  localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE_RD} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic [LAT_W-1:0] lat_cnt;
  logic             is_read;

  logic       b_ok, starved, grant_a, grant_b, b_serviced, wp_block;
  logic       sel_we;
  logic [7:0] sel_addr, sel_wdata;

  always_comb begin
    b_ok       = b_req && !a_lock;
    starved    = (starve_cnt == CNT_W'(MAX_WAIT));
    grant_b    = (state == IDLE) && b_ok && (starved || !a_req);
    grant_a    = (state == IDLE) && a_req && !grant_b;
    b_serviced = grant_b || ((state != IDLE) && owner);
    sel_we     = grant_b ? b_we    : a_we;
    sel_addr   = grant_b ? b_addr  : a_addr;
    sel_wdata  = grant_b ? b_wdata : a_wdata;
`ifdef ARB_WRITE_PROTECT_EN
    wp_block   = b_we && (b_addr < B_WR_MIN);
`else
    // floor stays referenced so both builds share one parameter set
    wp_block   = 1'b0 && (b_addr < B_WR_MIN);
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_b) begin
      starve_cnt <= '0;
    end else if (b_ok && !b_serviced && !starved) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      is_read   <= 1'b0;
      owner     <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      ram_write <= 1'b0;
      ram_read  <= 1'b0;
      ram_index <= '0;
      ram_wdata <= '0;
    end else begin
      ram_write <= 1'b0;
      ram_read  <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      b_err     <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            owner   <= grant_b;
            is_read <= !sel_we;
            state   <= ISSUE;
            if (grant_b && wp_block) begin
              b_ack <= 1'b1;
              b_err <= 1'b1;
            end else begin
              ram_index <= sel_addr;
              ram_write <= sel_we;
              ram_read  <= !sel_we;
              if (sel_we) begin
                ram_wdata <= sel_wdata;
                a_ack     <= !grant_b;
                b_ack     <= grant_b;
              end
            end
          end
        end
        ISSUE: begin
          if (is_read) begin
            lat_cnt <= '0;
            state   <= WAIT_RD;
          end else begin
            state <= IDLE;
          end
        end
        WAIT_RD: begin
          // capture on the last wait cycle so data and ack appear together in DONE_RD
          if (lat_cnt == LAT_W'(READ_LAT - 1)) begin
            state <= DONE_RD;
            if (owner) begin
              b_rdata <= ram_rdata;
              b_ack   <= 1'b1;
            end else begin
              a_rdata <= ram_rdata;
              a_ack   <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        DONE_RD: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Directed bench for reg_bus_arbiter: vector table for single accesses plus
// starvation, lock, and mid-access reset sequences.
module tb_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_req, a_we, a_lock;
  logic [7:0] a_addr, a_wdata;
  logic       b_req, b_we;
  logic [7:0] b_addr, b_wdata;
  logic       a_ack, b_ack, b_err;
  logic [7:0] a_rdata, b_rdata;
  logic       ram_write, ram_read;
  logic [7:0] ram_index, ram_wdata;
  logic [7:0] ram_rdata;
  logic       owner;

  int passed = 0;
  int total  = 0;

  logic [7:0] mem [256];

  always #5 clk = ~clk;

  reg_bus_arbiter #(.READ_LAT(1), .MAX_WAIT(15), .B_WR_MIN(8'h40)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_lock(a_lock),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .ram_write(ram_write), .ram_read(ram_read), .ram_index(ram_index),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .owner(owner)
  );

  // register module model: one cycle read latency
  always @(posedge clk) begin
    if (ram_write) mem[ram_index] <= ram_wdata;
    if (ram_read)  ram_rdata <= mem[ram_index];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (rst && ram_write && ram_read) check("strobe_exclusive", 32'd1, 32'd0);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       use_b;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       exp_wr;
    logic       exp_rd;
    logic [7:0] exp_rdata;
    logic       exp_err;
    int         exp_lat;
  } vec_t;

  vec_t vecs[12];

  task automatic run_vec(input vec_t v, input int idx);
    int   lat;
    logic got, other;
    @(negedge clk);
    if (v.use_b) begin
      b_req = 1'b1; b_we = v.we; b_addr = v.addr; b_wdata = v.wdata;
    end else begin
      a_req = 1'b1; a_we = v.we; a_addr = v.addr; a_wdata = v.wdata;
    end
    @(negedge clk);
    a_req = 1'b0; b_req = 1'b0;
    a_addr = ~v.addr; b_addr = ~v.addr; a_wdata = ~v.wdata; b_wdata = ~v.wdata;
    check($sformatf("v%0d_ram_write", idx), ram_write, v.exp_wr);
    check($sformatf("v%0d_ram_read", idx), ram_read, v.exp_rd);
    if (v.exp_wr || v.exp_rd) check($sformatf("v%0d_ram_index", idx), ram_index, v.addr);
    if (v.exp_wr) check($sformatf("v%0d_ram_wdata", idx), ram_wdata, v.wdata);
    check($sformatf("v%0d_owner", idx), owner, v.use_b);
    lat = 1;
    got = v.use_b ? b_ack : a_ack;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      got = v.use_b ? b_ack : a_ack;
    end
    other = v.use_b ? a_ack : b_ack;
    check($sformatf("v%0d_ack_latency", idx), lat, v.exp_lat);
    check($sformatf("v%0d_other_ack", idx), other, 1'b0);
    if (!v.we) check($sformatf("v%0d_rdata", idx), v.use_b ? b_rdata : a_rdata, v.exp_rdata);
    check($sformatf("v%0d_b_err", idx), b_err, v.exp_err);
    @(negedge clk);
    got = v.use_b ? b_ack : a_ack;
    check($sformatf("v%0d_ack_single", idx), got, 1'b0);
  endtask

  initial begin
    int   acnt, seg, cyc;
    logic seen, found;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h42] = 8'h33;
    ram_rdata = 8'h00;

    //            use_b we    addr   wdata  wr    rd    rdata  err   lat
    vecs[0]  = '{1'b0, 1'b1, 8'h41, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b0, 1};
    vecs[1]  = '{1'b1, 1'b0, 8'h42, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 3};
    vecs[2]  = '{1'b1, 1'b0, 8'h41, 8'h00, 1'b0, 1'b1, 8'h5A, 1'b0, 3};
    vecs[3]  = '{1'b0, 1'b0, 8'h42, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 3};
`ifdef ARB_WRITE_PROTECT_EN
    vecs[4]  = '{1'b1, 1'b1, 8'h10, 8'hC3, 1'b0, 1'b0, 8'h00, 1'b1, 1};
    vecs[5]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3};
`else
    vecs[4]  = '{1'b1, 1'b1, 8'h10, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b0, 1};
    vecs[5]  = '{1'b0, 1'b0, 8'h10, 8'h00, 1'b0, 1'b1, 8'hC3, 1'b0, 3};
`endif
    vecs[6]  = '{1'b1, 1'b1, 8'h40, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1};
    vecs[7]  = '{1'b1, 1'b0, 8'h40, 8'h00, 1'b0, 1'b1, 8'h77, 1'b0, 3};
    vecs[8]  = '{1'b0, 1'b1, 8'hFF, 8'hA5, 1'b1, 1'b0, 8'h00, 1'b0, 1};
    vecs[9]  = '{1'b0, 1'b0, 8'hFF, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 3};
    // run after the reset sequence: the reset-killed B write to 0x60 must not land
    vecs[10] = '{1'b0, 1'b0, 8'h60, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 3};
    vecs[11] = '{1'b1, 1'b1, 8'h61, 8'h3C, 1'b1, 1'b0, 8'h00, 1'b0, 1};

    rst = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_lock = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    #1;
    check("rst_a_ack", a_ack, 1'b0);
    check("rst_b_ack", b_ack, 1'b0);
    check("rst_b_err", b_err, 1'b0);
    check("rst_ram_write", ram_write, 1'b0);
    check("rst_ram_read", ram_read, 1'b0);
    check("rst_ram_index", ram_index, 8'h00);
    check("rst_ram_wdata", ram_wdata, 8'h00);
    check("rst_owner", owner, 1'b0);
    check("rst_a_rdata", a_rdata, 8'h00);
    check("rst_b_rdata", b_rdata, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // starvation: both masters request continuously
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h50; a_wdata = 8'h11;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h42;
    acnt = 0; seg = 0; cyc = 0;
    while (seg < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (a_ack) acnt++;
      if (b_ack) begin
        check($sformatf("starve_a_acks_seg%0d", seg), acnt, 8);
        check($sformatf("starve_b_rdata_seg%0d", seg), b_rdata, 8'h33);
        seg++;
        acnt = 0;
        if (seg == 2) begin a_req = 1'b0; b_req = 1'b0; end
      end
    end
    check("starve_b_served_twice", seg, 2);

    // lock holds B off; B follows promptly once lock drops
    @(negedge clk);
    a_lock = 1'b1; b_req = 1'b1; b_we = 1'b0; b_addr = 8'h42;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b_ack || ram_read) seen = 1'b1;
    end
    check("lock_blocks_b", seen, 1'b0);
    a_lock = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 2 && !found; i++) begin
      @(negedge clk);
      if (ram_read && owner) found = 1'b1;
    end
    check("unlock_b_grant", found, 1'b1);
    b_req = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 6 && !found; i++) begin
      @(negedge clk);
      if (b_ack) found = 1'b1;
    end
    check("unlock_b_ack", found, 1'b1);
    check("unlock_b_rdata", b_rdata, 8'h33);

    // counter frozen under lock: after release A still gets a full starvation window
    @(negedge clk);
    a_lock = 1'b1; a_req = 1'b1; a_we = 1'b1; a_addr = 8'h51; a_wdata = 8'h22;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h52; b_wdata = 8'h99;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (b_ack) seen = 1'b1;
    end
    check("lock2_blocks_b", seen, 1'b0);
    acnt = a_ack ? 1 : 0;
    a_lock = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (a_ack) acnt++;
      if (b_ack) found = 1'b1;
    end
    a_req = 1'b0; b_req = 1'b0;
    check("lock2_b_ack", found, 1'b1);
    check("lock2_a_acks_before_b", acnt, 8);

    // reset during WAIT_RD of an A read
    @(negedge clk);
    @(negedge clk);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h42;
    @(negedge clk);
    a_req = 1'b0;
    check("rstrd_ram_read", ram_read, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstrd_ram_read_low", ram_read, 1'b0);
    check("rstrd_ram_write_low", ram_write, 1'b0);
    check("rstrd_a_ack_low", a_ack, 1'b0);
    check("rstrd_ram_index", ram_index, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (a_ack) seen = 1'b1;
    end
    check("rstrd_no_late_ack", seen, 1'b0);

    // reset while a B write strobe is live: strobe and ack drop at once
    @(negedge clk);
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'h60; b_wdata = 8'hEE;
    @(negedge clk);
    b_req = 1'b0;
    check("rstwr_ram_write", ram_write, 1'b1);
    check("rstwr_b_ack", b_ack, 1'b1);
    rst = 1'b0;
    #1;
    check("rstwr_ram_write_low", ram_write, 1'b0);
    check("rstwr_b_ack_low", b_ack, 1'b0);
    check("rstwr_owner", owner, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 10; i < 12; i++) run_vec(vecs[i], i);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_bus_arbiter.md
Name: reg_bus_arbiter

Overview:
- Shares the single register-file access port (write / read_1 / index_1 / data bus) between two requesters.
- Requester A is the I2C slave: high priority, can lock the bus for a whole transaction.
- Requester B is an internal engine (autotune/ramp sequencer) that reads and writes PID/period registers.
- Sits between the requesters and the register module, on the divided clock.

Parameters:
- READ_LAT, 1, cycles from read_1 strobe to valid ram_rdata
- MAX_WAIT, 15, cycles B may wait (unlocked bus) before forced priority
- B_WR_MIN, 8'h40, lowest address B may write (used only with the optional feature)

Ports:
- clk  in  1  divided system clock
- rst  in  1  asynchronous, active-low reset
- a_req  in  1  A request, held until a_ack
- a_we  in  1  A write(1)/read(0)
- a_addr  in  8  A register index
- a_wdata  in  8  A write data
- a_lock  in  1  A transaction in progress (I2C busy); B cannot be granted while high
- a_ack  out  1  one-cycle completion pulse to A
- a_rdata  out  8  A read data, valid with a_ack
- b_req, b_we, b_addr[7:0], b_wdata[7:0]  in  same meaning for B
- b_ack  out  1  one-cycle completion pulse to B
- b_rdata  out  8  B read data, valid with b_ack
- b_err  out  1  valid with b_ack; B write rejected (optional feature)
- ram_write  out  1  write strobe to register module
- ram_read  out  1  read strobe (read_1)
- ram_index  out  8  register index
- ram_wdata  out  8  write data
- ram_rdata  in  8  read data from register module
- owner  out  1  0 = A, 1 = B; last/current grant

Behaviour:
- Reset: all outputs 0, state IDLE, starvation counter 0, owner 0. Reset is asynchronous and may occur mid-operation: strobes drop immediately and any in-flight access is lost without an ack.
- States: IDLE, ISSUE, WAIT_RD, DONE_RD.
- IDLE arbitration, evaluated each cycle:
  - B is grantable only if b_req && !a_lock.
  - Starved (counter == MAX_WAIT) and B grantable → grant B.
  - Else a_req → grant A.
  - Else B grantable → grant B.
  - Else stay in IDLE.
- Request fields are sampled into holding registers at grant. Later changes and an early req drop do not cancel the access; the ack still pulses.
- Write granted in cycle N: in N+1, ram_write=1, ram_index/ram_wdata are driven, and x_ack=1 for exactly one cycle. Return to IDLE at N+2; the next grant is possible at N+2.
- Read granted in cycle N: ram_read=1 in N+1, then WAIT_RD for READ_LAT cycles. In DONE_RD, ram_rdata is captured into x_rdata and x_ack pulses at cycle N+2+READ_LAT. Then IDLE.
- ram_index/ram_wdata hold their last value when idle. Strobes are single-cycle and never both high.
- Starvation counter:
  - Increments, saturating at MAX_WAIT, each cycle b_req && !a_lock && B not being serviced.
  - Clears on B grant.
  - Holds while a_lock is high.
- Requester contract: deassert req the cycle after ack, or keep it high to queue a new access. With both requesters continuously requesting and no lock, A is served until the counter saturates, then B is served once.
- owner updates at grant and holds through the access.
- Widths: counter is $clog2(MAX_WAIT+1) bits. No arithmetic on data.

Optional Feature:
- Macro: ARB_WRITE_PROTECT_EN.
- Defined: a B write with b_addr < B_WR_MIN is rejected. No ram_write strobe is issued; b_ack and b_err pulse together at N+1. b_err is 0 for all other accesses.
- Undefined: no address check; b_err is tied 0.

Test Plan:
- A write 0x41←0x5A, B idle → ram_write=1, ram_index=0x41, ram_wdata=0x5A, a_ack all in cycle after grant; owner=0.
- B read 0x42, ram model returns 0x33 after READ_LAT=1 → ram_read one cycle after grant; b_ack with b_rdata=0x33 exactly 3 cycles after grant.
- A and B request simultaneously, a_lock low, A re-requests continuously → A served until counter hits 15, then exactly one B grant, counter back to 0.
- a_lock=1 for 40 cycles with b_req=1 → no B grant, counter frozen; B granted within 2 cycles after a_lock falls.
- Assert rst low during WAIT_RD of an A read → all strobes/acks 0 immediately; no a_ack after release; next request completes normally.
- With ARB_WRITE_PROTECT_EN: B write to 0x10 → b_ack=b_err=1, no ram_write. B write to 0x40 → normal write with b_err=0.
